bit_class_accumulator: RTL
==========================

Name: bit_class_accumulator

Overview:
Streaming, parametrised successor to the 4-bit combinational ones/zeros/X-Z counter. Accepts WIDTH-bit beats over a valid/ready handshake and classifies every bit of each beat as 1, 0 or X/Z. Accumulates the three counts over a frame delimited by in_last, then presents the totals on a held, back-pressured output. Sits in the data-integrity/verification-assist path, downstream of any stream source.

Parameters:
WIDTH, 8, bits per input beat (>=1)
ACC_W, 8, width of each frame accumulator and output count (>= $clog2(WIDTH+1))

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  beat present
in_ready  output  1  block can accept a beat
in_data  input  WIDTH  beat payload (4-state in simulation)
in_last  input  1  beat is the final beat of the frame
out_valid  output  1  frame totals valid
out_ready  input  1  consumer takes totals
ones_cnt  output  ACC_W  count of bits ==1 in the frame
zeros_cnt  output  ACC_W  count of bits ==0 in the frame
xz_cnt  output  ACC_W  count of bits that are X or Z in the frame
sat  output  1  sticky: at least one accumulator saturated this frame

Behaviour:
- Single clock, clk. Reset is asynchronous and active-high on rst. While rst is high: state=ACCUM, all accumulators=0, sat=0, out_valid=0, in_ready=1, all counts 0.
- Per-beat classification is combinational via sub-module. Uses case-equality, so xz counts are meaningful in simulation only; synthesised hardware reports xz_cnt=0.
- Invariant per beat: ones+zeros+xz = WIDTH.
- FSM has 2 states:
  - ACCUM: in_ready=1, out_valid=0. On an accepted beat (in_valid&in_ready), each accumulator adds its per-beat count. If in_last is also set, go to HOLD.
  - HOLD: in_ready=0, out_valid=1, totals and sat stable. On out_ready, clear accumulators and sat, then return to ACCUM.
- Latency: out_valid asserts the cycle after the in_last beat is accepted. Totals include that beat.
- Throughput: one beat per cycle inside a frame. There is one dead input cycle per frame (the HOLD handshake cycle); a beat offered in HOLD is accepted in the cycle after the out_ready handshake.
- Arithmetic: per-beat counts are $clog2(WIDTH+1) bits, zero-extended to ACC_W. Each addition saturates at 2^ACC_W-1. Any saturating add sets sat, which holds until the frame is consumed.
- in_valid while in HOLD: ignored, not lost (source holds per handshake rules).
- Reset mid-frame or mid-HOLD: partial totals discarded, back to the reset state immediately.
- out_ready while not out_valid: no effect.

Optional Feature:
BIT_CLASS_PARITY_EN
- Defined: adds output out_parity (1 bit) = XOR of all bits ==1 over the frame. It is accumulated alongside the counts, valid with out_valid, cleared with the accumulators, and 0 in reset.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Package bit_class_pkg contains:
  - state enum {ACCUM, HOLD}
  - localparam function for per-beat count width
  - saturating-add function, parametrised on ACC_W via argument width
- Sub-module bit_classifier (combinational, WIDTH param): in_data -> ones/zeros/xz per-beat counts.

Test Plan:
1. Reset held 3 cycles, then released -> in_ready=1, out_valid=0, all counts 0, sat=0.
2. Single beat 8'b1011_0010 with in_last=1 -> next cycle out_valid=1, ones_cnt=4, zeros_cnt=4, xz_cnt=0, sat=0.
3. Three-beat frame 8'hFF, 8'h00, 8'b1x0z_1111 (last) -> ones_cnt=13, zeros_cnt=9, xz_cnt=2.
4. Frame done with out_ready=0 for 5 cycles and in_valid=1 (8'h0F) -> in_ready=0 and totals stable for 5 cycles. Then out_ready=1 -> out_valid=0 next cycle, and the 8'h0F beat is accepted the following cycle.
5. ACC_W=8: 40 beats of 8'hFF, last on beat 40 -> ones_cnt=255, zeros_cnt=0, sat=1. The next frame, single 8'h01, gives ones_cnt=1, zeros_cnt=7, sat=0.
6. Two beats 8'hFF accepted, then async rst pulse mid-cycle -> counts clear immediately. A fresh single beat 8'h03 (last) gives ones_cnt=2, zeros_cnt=6.

Source files
------------

// File: rtl/bit_class_pkg.sv
// ============================================================================
// Module   : bit_class_pkg
// Purpose  : Shared types and helpers for the bit-class accumulator.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package bit_class_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    localparam int MAX_ACC_W = 32;

    typedef struct packed {
        logic [MAX_ACC_W-1:0] sum;
        logic                 sat;
    } sat_add_t;

    function automatic int beat_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

    // Operands are zero-extended to MAX_ACC_W; acc_w selects the clamp point.
    function automatic sat_add_t sat_add(input logic [MAX_ACC_W-1:0] a,
                                         input logic [MAX_ACC_W-1:0] b,
                                         input int                   acc_w);
        sat_add_t           r;
        logic [MAX_ACC_W:0] full;
        logic [MAX_ACC_W:0] lim;
        full = {1'b0, a} + {1'b0, b};
        lim  = ({{MAX_ACC_W{1'b0}}, 1'b1} << acc_w) - {{MAX_ACC_W{1'b0}}, 1'b1};
        if (full > lim) begin
            r.sum = lim[MAX_ACC_W-1:0];
            r.sat = 1'b1;
        end else begin
            r.sum = full[MAX_ACC_W-1:0];
            r.sat = 1'b0;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bit_classifier.sv
// ============================================================================
// Module   : bit_classifier
// Purpose  : Combinational per-beat count of bits that are 1, 0 and X/Z.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module bit_classifier
    import bit_class_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]             data_i,
    output logic [beat_cnt_w(WIDTH)-1:0] ones_o,
    output logic [beat_cnt_w(WIDTH)-1:0] zeros_o,
    output logic [beat_cnt_w(WIDTH)-1:0] xz_o
);

    localparam int CW = beat_cnt_w(WIDTH);

    // Case equality lets X/Z fall through in simulation; hardware never sees them.
    always_comb begin
        ones_o  = '0;
        zeros_o = '0;
        xz_o    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (data_i[i] === 1'b1) begin
                ones_o = ones_o + CW'(1);
            end else if (data_i[i] === 1'b0) begin
                zeros_o = zeros_o + CW'(1);
            end else begin
                xz_o = xz_o + CW'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/bit_class_accumulator.sv
// ============================================================================
// Module   : bit_class_accumulator
// Purpose  : Frame-wise 1/0/X-Z bit counter with held, back-pressured totals.
//            Define BIT_CLASS_PARITY_EN to add the out_parity output.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module bit_class_accumulator
    import bit_class_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ACC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] ones_cnt,
    output logic [ACC_W-1:0] zeros_cnt,
    output logic [ACC_W-1:0] xz_cnt,
    output logic             sat
`ifdef BIT_CLASS_PARITY_EN
    ,
    output logic             out_parity
`endif
);

    localparam int CW = beat_cnt_w(WIDTH);

    state_e           state_q, state_d;
    logic [ACC_W-1:0] ones_q, ones_d;
    logic [ACC_W-1:0] zeros_q, zeros_d;
    logic [ACC_W-1:0] xz_q, xz_d;
    logic             sat_q, sat_d;
    logic [CW-1:0]    beat_ones, beat_zeros, beat_xz;
    sat_add_t         add_ones, add_zeros, add_xz;
    logic             unused_sum_bits;

    bit_classifier #(
        .WIDTH (WIDTH)
    ) u_classifier (
        .data_i  (in_data),
        .ones_o  (beat_ones),
        .zeros_o (beat_zeros),
        .xz_o    (beat_xz)
    );

    assign add_ones  = sat_add(MAX_ACC_W'(ones_q),  MAX_ACC_W'(beat_ones),  ACC_W);
    assign add_zeros = sat_add(MAX_ACC_W'(zeros_q), MAX_ACC_W'(beat_zeros), ACC_W);
    assign add_xz    = sat_add(MAX_ACC_W'(xz_q),    MAX_ACC_W'(beat_xz),    ACC_W);
    assign unused_sum_bits = ^{add_ones.sum, add_zeros.sum, add_xz.sum};

`ifdef BIT_CLASS_PARITY_EN
    logic parity_q, parity_d;
    assign out_parity = parity_q;
`endif

    always_comb begin
        state_d   = state_q;
        ones_d    = ones_q;
        zeros_d   = zeros_q;
        xz_d      = xz_q;
        sat_d     = sat_q;
`ifdef BIT_CLASS_PARITY_EN
        parity_d  = parity_q;
`endif
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    ones_d  = add_ones.sum[ACC_W-1:0];
                    zeros_d = add_zeros.sum[ACC_W-1:0];
                    xz_d    = add_xz.sum[ACC_W-1:0];
                    sat_d   = sat_q | add_ones.sat | add_zeros.sat | add_xz.sat;
`ifdef BIT_CLASS_PARITY_EN
                    // Parity of the ones in a beat is the LSB of its ones count.
                    parity_d = parity_q ^ beat_ones[0];
`endif
                    if (in_last) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    ones_d  = '0;
                    zeros_d = '0;
                    xz_d    = '0;
                    sat_d   = 1'b0;
`ifdef BIT_CLASS_PARITY_EN
                    parity_d = 1'b0;
`endif
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ACCUM;
            ones_q   <= '0;
            zeros_q  <= '0;
            xz_q     <= '0;
            sat_q    <= 1'b0;
`ifdef BIT_CLASS_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ones_q   <= ones_d;
            zeros_q  <= zeros_d;
            xz_q     <= xz_d;
            sat_q    <= sat_d;
`ifdef BIT_CLASS_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign ones_cnt  = ones_q;
    assign zeros_cnt = zeros_q;
    assign xz_cnt    = xz_q;
    assign sat       = sat_q;

endmodule

`default_nettype wire
